h_bdy_eng_iss: RTL and testbench

// - Issue stage for the body-engine execute unit: sole producer of its command stream.
// - Buffers upstream commands in an in-order FIFO and issues them under a credit limit.
// - Retires credits on completion pulses from the execute stage.
// - Provides flush/drain so the execute side can be quiesced cleanly.

---
 rtl/h_bdy_eng_iss.sv | 210 +++++++++++++++++++++
 tb/tb_h_bdy_eng_iss.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_bdy_eng_iss.sv
// ---------------------------------------------------------------------------
// h_bdy_eng_iss -- issue stage for the body-engine execute unit.
//
// Holds upstream commands in an in-order FIFO and issues them to the execute
// stage. No more than CREDITS commands may be issued and not yet completed.
// A flush throws away the queued commands and then waits until every
// outstanding command has completed.
//
// Handshake rule, used by both interfaces: a transfer happens on a rising clk
// edge where valid and ready are both 1. Valid never depends on ready. While
// valid is high and ready is low, the payload and tag do not change. Ready is
// a combinational function of registered state only.
//
// Ports:
//   clk, arst_n      clock; asynchronous active-low reset
//   cmd_vld_i/cmd_i  upstream command; cmd_rdy_o accepts it
//   exe_vld_o/exe_cmd_o/exe_tag_o  command to exe, issued on exe_rdy_i
//   exe_cmpl_i       completion pulse from exe; returns one credit
//   flush_i          discard the queue and drain outstanding commands
//   flush_done_o     one-cycle pulse on the cycle the drain finishes
//   occ_o            FIFO occupancy
//   err_o            sticky; set by a completion when nothing is outstanding
//   stall_cnt_o      saturating count of stalled cycles
//                    (only when H_BDY_ENG_ISS_STALL_CNT_EN is defined)
//   dbg_state_o      FSM state: 0 IDLE, 1 RUN, 2 DRAIN
//
// Optional feature macro: H_BDY_ENG_ISS_STALL_CNT_EN
// ---------------------------------------------------------------------------
module h_bdy_eng_iss #(
    parameter int DEPTH   = 4,
    parameter int CMD_W   = 32,
    parameter int CREDITS = 2,
    parameter int TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         cmd_vld_i,
    input  logic [CMD_W-1:0]             cmd_i,
    output logic                         cmd_rdy_o,
    output logic                         exe_vld_o,
    output logic [CMD_W-1:0]             exe_cmd_o,
    output logic [TAG_W-1:0]             exe_tag_o,
    input  logic                         exe_rdy_i,
    input  logic                         exe_cmpl_i,
    input  logic                         flush_i,
    output logic                         flush_done_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o,
    output logic                         err_o,
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
    output logic [31:0]                  stall_cnt_o,
`endif
    output logic [1:0]                   dbg_state_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CRD_W = $clog2(CREDITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CRD_W-1:0] credits_q, credits_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;

    logic empty, full, push, issue, cmpl_ok, flush_go, drain_done;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(DEPTH));

    // arst_n is included so that every output reads 0 while reset is held.
    assign cmd_rdy_o = arst_n && !full && (state_q != ST_DRAIN);
    assign exe_vld_o = !empty && (credits_q != '0) && (state_q != ST_DRAIN);
    // An empty FIFO shows 0 rather than the stale slot under the read pointer.
    assign exe_cmd_o = empty ? '0 : mem_q[rd_ptr_q];
    assign exe_tag_o = tag_q;
    assign occ_o     = occ_q;
    assign err_o     = err_q;
    assign dbg_state_o = state_q;

    assign push     = cmd_vld_i && cmd_rdy_o;
    assign issue    = exe_vld_o && exe_rdy_i;
    // A completion counts only when a command is actually outstanding.
    assign cmpl_ok  = exe_cmpl_i && (credits_q != CRD_W'(CREDITS));
    assign flush_go = flush_i && (state_q != ST_DRAIN);
    // The drain finishes on the cycle the last credit comes back, including
    // the completion that arrives in that same cycle.
    assign drain_done = (state_q == ST_DRAIN) &&
                        ((credits_q == CRD_W'(CREDITS)) ||
                         (cmpl_ok && (credits_q == CRD_W'(CREDITS - 1))));
    assign flush_done_o = drain_done;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush_go) begin
            // An issue in the flush cycle still takes place. The FIFO
            // contents, including any push in this cycle, are dropped.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = cmd_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !issue) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (!push && issue) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (issue && !cmpl_ok) begin
            credits_d = credits_q - CRD_W'(1);
        end else if (!issue && cmpl_ok) begin
            credits_d = credits_q + CRD_W'(1);
        end
        tag_d = issue ? tag_q + TAG_W'(1) : tag_q;
        err_d = err_q || (exe_cmpl_i && !cmpl_ok);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_go) begin
                    state_d = ST_DRAIN;
                end else if (push) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_go) begin
                    state_d = ST_DRAIN;
                end else if (empty && !push && (credits_q == CRD_W'(CREDITS))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            credits_q <= CRD_W'(CREDITS);
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            credits_q <= credits_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
        end
    end

    // Storage has no reset. Reads are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (exe_vld_o && !exe_rdy_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_h_bdy_eng_iss.sv
module tb_h_bdy_eng_iss;

    localparam int DEPTH   = 4;
    localparam int CMD_W   = 32;
    localparam int CREDITS = 2;
    localparam int TAG_W   = 4;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_vld_i = 1'b0;
    logic [CMD_W-1:0]  cmd_i = '0;
    logic              cmd_rdy_o;
    logic              exe_vld_o;
    logic [CMD_W-1:0]  exe_cmd_o;
    logic [TAG_W-1:0]  exe_tag_o;
    logic              exe_rdy_i = 1'b0;
    logic              exe_cmpl_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              flush_done_o;
    logic [OCC_W-1:0]  occ_o;
    logic              err_o;
    logic [1:0]        dbg_state_o;
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
    logic [31:0]       stall_cnt_o;
`endif

    h_bdy_eng_iss #(
        .DEPTH(DEPTH), .CMD_W(CMD_W), .CREDITS(CREDITS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .cmd_vld_i(cmd_vld_i),
        .cmd_i(cmd_i),
        .cmd_rdy_o(cmd_rdy_o),
        .exe_vld_o(exe_vld_o),
        .exe_cmd_o(exe_cmd_o),
        .exe_tag_o(exe_tag_o),
        .exe_rdy_i(exe_rdy_i),
        .exe_cmpl_i(exe_cmpl_i),
        .flush_i(flush_i),
        .flush_done_o(flush_done_o),
        .occ_o(occ_o),
        .err_o(err_o),
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- behavioural model ----------------
    logic [CMD_W-1:0] exp_q[$];   // commands queued, oldest first
    int               outst;      // issued and not completed
    int               m_tag;
    bit               m_drain;
    bit               m_err;
    logic [31:0]      m_stall;

    int checks = 0;
    int errors = 0;

    // captured from the DUT during the last step, for literal checks
    logic             last_fd;
    logic             last_issue;
    logic [TAG_W-1:0] last_tag;
    logic [CMD_W-1:0] last_cmd;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        outst   = 0;
        m_tag   = 0;
        m_drain = 0;
        m_err   = 0;
        m_stall = '0;
    endfunction

    // Compares the outputs for the inputs now applied, then moves the
    // model on by one clock.
    task automatic compare_and_update();
        bit e_rdy, e_vld, push, iss, cok, done;
        logic [CMD_W-1:0] e_cmd;
        e_rdy = !m_drain && (exp_q.size() < DEPTH);
        e_vld = !m_drain && (exp_q.size() > 0) && (outst < CREDITS);
        e_cmd = (exp_q.size() > 0) ? exp_q[0] : '0;
        cok   = exe_cmpl_i && (outst > 0);
        done  = m_drain && ((outst - int'(cok)) == 0);

        chk("cmd_rdy_o",    64'(cmd_rdy_o),    64'(e_rdy));
        chk("exe_vld_o",    64'(exe_vld_o),    64'(e_vld));
        chk("exe_cmd_o",    64'(exe_cmd_o),    64'(e_cmd));
        chk("exe_tag_o",    64'(exe_tag_o),    64'(m_tag));
        chk("flush_done_o", 64'(flush_done_o), 64'(done));
        chk("occ_o",        64'(occ_o),        64'(exp_q.size()));
        chk("err_o",        64'(err_o),        64'(m_err));
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
        chk("stall_cnt_o",  64'(stall_cnt_o),  64'(m_stall));
`endif
        last_fd    = flush_done_o;
        last_issue = exe_vld_o && exe_rdy_i;
        last_tag   = exe_tag_o;
        last_cmd   = exe_cmd_o;

        push = cmd_vld_i && e_rdy;
        iss  = e_vld && exe_rdy_i;
        if (e_vld && !exe_rdy_i && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
        if (exe_cmpl_i && !cok) m_err = 1;
        outst = outst + int'(iss) - int'(cok);
        if (iss) begin
            void'(exp_q.pop_front());
            m_tag = (m_tag + 1) % (1 << TAG_W);
        end
        if (flush_i && !m_drain) begin
            exp_q.delete();
            m_drain = 1;
        end else begin
            if (push) exp_q.push_back(cmd_i);
            if (done) m_drain = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Starts at a falling edge and ends at the next one.
    task automatic step(input logic v, input logic [CMD_W-1:0] c, input logic r,
                        input logic cp, input logic fl);
        cmd_vld_i  = v;
        cmd_i      = c;
        exe_rdy_i  = r;
        exe_cmpl_i = cp;
        flush_i    = fl;
        #1;
        compare_and_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        cmd_vld_i  = 0;
        exe_rdy_i  = 0;
        exe_cmpl_i = 0;
        flush_i    = 0;
        arst_n     = 0;
        #1;
        chk("rst cmd_rdy_o",    64'(cmd_rdy_o),    64'd0);
        chk("rst exe_vld_o",    64'(exe_vld_o),    64'd0);
        chk("rst exe_cmd_o",    64'(exe_cmd_o),    64'd0);
        chk("rst exe_tag_o",    64'(exe_tag_o),    64'd0);
        chk("rst flush_done_o", 64'(flush_done_o), 64'd0);
        chk("rst occ_o",        64'(occ_o),        64'd0);
        chk("rst err_o",        64'(err_o),        64'd0);
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
        chk("rst stall_cnt_o",  64'(stall_cnt_o),  64'd0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arst_n = 1;
    endtask

    // ---------------- scenario ----------------
    initial begin
        logic [CMD_W-1:0] hold_cmd;
        logic [TAG_W-1:0] hold_tag;
        logic [TAG_W-1:0] tags[$];

        model_reset();
        @(negedge clk);
        apply_reset();

        // Four pushes with exe ready and no completions: only two issue.
        for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 1, 0, 0);
        chk("four pushes occ", 64'(occ_o), 64'd2);
        chk("four pushes vld", 64'(exe_vld_o), 64'd0);
        chk("four pushes tag", 64'(exe_tag_o), 64'd2);

        // Fill to full, then release one credit and issue.
        step(1, 32'hA4, 1, 0, 0);
        step(1, 32'hA5, 1, 0, 0);
        chk("full occ", 64'(occ_o), 64'd4);
        chk("full rdy", 64'(cmd_rdy_o), 64'd0);
        step(1, 32'hA6, 1, 1, 0);
        chk("full still blocked", 64'(cmd_rdy_o), 64'd0);
        step(1, 32'hA6, 1, 0, 0);
        chk("issue from full cmd", 64'(last_cmd), 64'hA2);
        chk("issue from full tag", 64'(last_tag), 64'd2);
        chk("space after issue", 64'(cmd_rdy_o), 64'd1);
        chk("occ after issue", 64'(occ_o), 64'd3);

        // Stall for five cycles: payload and tag must hold.
        step(0, 0, 0, 1, 0);
        hold_cmd = exe_cmd_o;
        hold_tag = exe_tag_o;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("stall cmd stable", 64'(exe_cmd_o), 64'(hold_cmd));
            chk("stall tag stable", 64'(exe_tag_o), 64'(hold_tag));
        end
        chk("stall head", 64'(exe_cmd_o), 64'hA3);
        chk("stall tag", 64'(exe_tag_o), 64'd3);
`ifdef H_BDY_ENG_ISS_STALL_CNT_EN
        chk("stall count", 64'(stall_cnt_o), 64'd5);
`endif

        // Issue and completion in one cycle leave the credit count alone.
        step(0, 0, 1, 1, 0);
        chk("issue+cmpl vld", 64'(exe_vld_o), 64'd1);
        step(0, 0, 1, 0, 0);
        chk("credits used up", 64'(exe_vld_o), 64'd0);

        // Reset while commands are in flight.
        apply_reset();

        // Flush with three queued and two outstanding.
        for (int i = 0; i < 5; i++) step(1, 32'hB0 + i, 1, 0, 0);
        chk("pre-flush occ", 64'(occ_o), 64'd3);
        step(0, 0, 1, 0, 1);
        chk("flush rdy", 64'(cmd_rdy_o), 64'd0);
        chk("flush occ", 64'(occ_o), 64'd0);
        chk("flush keeps tag", 64'(exe_tag_o), 64'd2);
        step(0, 0, 1, 0, 0);
        chk("no done yet", 64'(last_fd), 64'd0);
        step(0, 0, 1, 1, 0);
        chk("no done on 1st cmpl", 64'(last_fd), 64'd0);
        step(0, 0, 1, 1, 0);
        chk("done on 2nd cmpl", 64'(last_fd), 64'd1);
        chk("idle after drain", 64'(dbg_state_o), 64'd0);
        chk("ready after drain", 64'(cmd_rdy_o), 64'd1);

        // Flush with nothing outstanding finishes the cycle after.
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("quick flush done", 64'(last_fd), 64'd1);

        // A completion with nothing outstanding sets the sticky error.
        step(0, 0, 1, 1, 0);
        chk("err set", 64'(err_o), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("err sticky", 64'(err_o), 64'd1);

        // Tag wrap across 17 issues.
        apply_reset();
        for (int i = 0; i < 400 && tags.size() < 17; i++) begin
            step(1, 32'hC00 + i, 1, (outst > 0) && ($urandom_range(0, 1) == 1), 0);
            if (last_issue) tags.push_back(last_tag);
        end
        chk("17 issues within budget", 64'(tags.size() >= 17), 64'd1);
        if (tags.size() >= 17) begin
            chk("first tag", 64'(tags[0]), 64'd0);
            chk("tag 15", 64'(tags[15]), 64'd15);
            chk("tag wrap", 64'(tags[16]), 64'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 ((outst > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 199) == 0),
                 $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
